// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RISC-V funct3
// encodings and the request legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture,
        StResp
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only exist for loads; halfwords and words must be naturally aligned.
    function automatic logic lsu_legal(input logic wr, input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~wr;
            F3_HU:   ok = ~wr & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory-stage request at a time, checks it, drives
// data_mem's synchronous port and returns a registered response with an error flag.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  dmem_wren,
    output logic [2:0]            funct3,
    output logic [ADDR_WIDTH-1:0] dmem_address,
    output logic [DATA_WIDTH-1:0] dmem_data_in,
    input  logic [DATA_WIDTH-1:0] dmem_data_out
);

    lsu_state_e            state_q, state_d;
    logic                  wr_q, wr_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    if (lsu_legal(req_wr, req_funct3, req_addr[1:0])) begin
                        err_d   = 1'b0;
                        state_d = StIssue;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StIssue: begin
                state_d = wr_q ? StResp : StCapture;
            end
            StCapture: begin
                rdata_d = dmem_data_out;
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // dmem_wren is gated by reset so a store whose ISSUE edge meets reset never writes.
    assign req_ready    = (state_q == StIdle) && reset;
    assign resp_valid   = (state_q == StResp);
    assign resp_rdata   = rdata_q;
    assign resp_err     = err_q;
    assign dmem_wren    = (state_q == StIssue) && wr_q && reset;
    assign funct3       = f3_q;
    assign dmem_address = addr_q;
    assign dmem_data_in = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural data_mem (RAM,
// LED register at 0xFFFFFFFC, millis counter at 0xFFFFFFF8).
module tb_load_store_unit;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam int unsigned MillisDiv = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        dmem_wren;
    logic [2:0]  funct3;
    logic [31:0] dmem_address, dmem_data_in, dmem_data_out;

    int n_checks = 0;
    int n_fail   = 0;
    int wren_count = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .dmem_wren     (dmem_wren),
        .funct3        (funct3),
        .dmem_address  (dmem_address),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out)
    );

    // Behavioural data_mem: synchronous write, registered formatted read.
    logic [31:0] mem [64];
    logic [31:0] led_q = '0;
    logic [31:0] millis_q = '0;
    int unsigned div_q = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] r;
        r = old;
        case (f3[1:0])
            2'b00:   r[{a, 3'b000} +: 8] = wd[7:0];
            2'b01:   r[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (f3)
            LB:      return {{24{b[7]}}, b};
            LBU:     return {24'b0, b};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'b0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] raw_read(input logic [31:0] a);
        if (a == 32'hFFFF_FFFC) return led_q;
        if (a == 32'hFFFF_FFF8) return millis_q;
        if (a < 32'd256) return mem[a[7:2]];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (dmem_wren === 1'b1) begin
            wren_count <= wren_count + 1;
            if (dmem_address == 32'hFFFF_FFFC)
                led_q <= merge(led_q, dmem_data_in, funct3, dmem_address[1:0]);
            else if (dmem_address < 32'd256)
                mem[dmem_address[7:2]] <= merge(mem[dmem_address[7:2]], dmem_data_in, funct3,
                                                dmem_address[1:0]);
        end
        dmem_data_out <= fmt(raw_read(dmem_address), funct3, dmem_address[1:0]);
        if (div_q == MillisDiv - 1) begin
            div_q    <= 0;
            millis_q <= millis_q + 1;
        end else begin
            div_q <= div_q + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; lat counts cycles from the accept cycle to the first resp_valid cycle.
    task automatic txn(input string tag, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat);
        int t;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        t = 0;
        while (req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " accept"}, {31'b0, req_ready}, 32'd1);
        lat = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (resp_valid !== 1'b1 && lat < 20);
        rdata = resp_rdata;
        err   = resp_err;
        for (int i = 0; i < hold; i++) begin
            chk({tag, " hold req_ready"}, {31'b0, req_ready}, 32'd0);
            @(negedge clk);
            chk({tag, " hold valid"}, {31'b0, resp_valid}, 32'd1);
            chk({tag, " hold rdata"}, resp_rdata, rdata);
            chk({tag, " hold err"}, {31'b0, resp_err}, {31'b0, err});
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " valid drop"}, {31'b0, resp_valid}, 32'd0);
    endtask

    logic [31:0] rd, m1, m2;
    logic        er;
    int          lat, w0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset = 1'b0; req_valid = 1'b1; req_wr = 1'b1; req_funct3 = LW;
        req_addr = 32'h40; req_wdata = 32'h1234_5678; resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst dmem_wren", {31'b0, dmem_wren}, 32'd0);
        chk("rst funct3", {29'b0, funct3}, 32'd0);
        chk("rst dmem_address", dmem_address, 32'd0);
        chk("rst dmem_data_in", dmem_data_in, 32'd0);
        chk("rst no write", wren_count, 32'd0);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("idle req_ready", {31'b0, req_ready}, 32'd1);

        txn("sw 0x10", 1'b1, LW, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
        chk("sw lat", lat, 32'd2);
        chk("sw err", {31'b0, er}, 32'd0);
        chk("sw rdata", rd, 32'd0);
        chk("sw wren pulses", wren_count, 32'd1);
        txn("lw 0x10", 1'b0, LW, 32'h10, 32'h0, 0, rd, er, lat);
        chk("lw lat", lat, 32'd3);
        chk("lw err", {31'b0, er}, 32'd0);
        chk("lw rdata", rd, 32'hDEAD_BEEF);

        txn("sb 0x21", 1'b1, LB, 32'h21, 32'h80, 0, rd, er, lat);
        chk("sb err", {31'b0, er}, 32'd0);
        txn("lb 0x21", 1'b0, LB, 32'h21, 32'h0, 0, rd, er, lat);
        chk("lb rdata", rd, 32'hFFFF_FF80);
        txn("lbu 0x21", 1'b0, LBU, 32'h21, 32'h0, 0, rd, er, lat);
        chk("lbu rdata", rd, 32'h0000_0080);

        w0 = wren_count;
        txn("lh 0x13", 1'b0, LH, 32'h13, 32'h0, 0, rd, er, lat);
        chk("lh mis lat", lat, 32'd1);
        chk("lh mis err", {31'b0, er}, 32'd1);
        chk("lh mis rdata", rd, 32'd0);
        txn("sw 0x22", 1'b1, LW, 32'h22, 32'hFFFF_FFFF, 0, rd, er, lat);
        chk("sw mis err", {31'b0, er}, 32'd1);
        chk("err no write", wren_count, w0);
        txn("lw 0x20", 1'b0, LW, 32'h20, 32'h0, 0, rd, er, lat);
        chk("word 0x20 unchanged", rd, 32'h0000_8000);
        txn("f3 011", 1'b0, 3'b011, 32'h3, 32'h0, 0, rd, er, lat);
        chk("f3 011 err", {31'b0, er}, 32'd1);
        txn("sbu illegal", 1'b1, LBU, 32'h20, 32'h0, 0, rd, er, lat);
        chk("store f3 100 err", {31'b0, er}, 32'd1);
        txn("lhu 0x22", 1'b0, LHU, 32'h22, 32'h0, 0, rd, er, lat);
        chk("lhu rdata", rd, 32'h0000_0000);
        txn("lh 0x20", 1'b0, LH, 32'h20, 32'h0, 0, rd, er, lat);
        chk("lh rdata", rd, 32'hFFFF_8000);

        txn("sw led", 1'b1, LW, 32'hFFFF_FFFC, 32'h00FF_0000, 0, rd, er, lat);
        chk("led err", {31'b0, er}, 32'd0);
        chk("led value", led_q, 32'h00FF_0000);
        txn("millis 1", 1'b0, LW, 32'hFFFF_FFF8, 32'h0, 0, m1, er, lat);
        repeat (MillisDiv + 100) @(posedge clk);
        txn("millis 2", 1'b0, LW, 32'hFFFF_FFF8, 32'h0, 0, m2, er, lat);
        chk("millis advance", {31'b0, (m2 >= m1 + 1)}, 32'd1);

        txn("lw hold", 1'b0, LW, 32'h10, 32'h0, 5, rd, er, lat);
        chk("lw hold rdata", rd, 32'hDEAD_BEEF);

        txn("sw 0x30", 1'b1, LW, 32'h30, 32'h1111_2222, 0, rd, er, lat);
        w0 = wren_count;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_funct3 = LW;
        req_addr = 32'h30; req_wdata = 32'hAAAA_AAAA;
        chk("rst-abort accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst-abort wren gated", {31'b0, dmem_wren}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst-abort no resp", {31'b0, resp_valid}, 32'd0);
        chk("rst-abort no write", wren_count, w0);
        repeat (3) @(negedge clk);
        chk("rst-abort still no resp", {31'b0, resp_valid}, 32'd0);
        txn("lw 0x30", 1'b0, LW, 32'h30, 32'h0, 0, rd, er, lat);
        chk("lw 0x30 prior value", rd, 32'h1111_2222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
